// File: rtl/sim_ctrl_arbiter.sv
// sim_ctrl_arbiter: round-robin write-channel arbiter in front of the simulator-control peripheral.
module sim_ctrl_arbiter #(
   parameter int NumReq   = 2,
   parameter int BTimeout = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NumReq-1:0]    req_awvalid_i,
   input  logic [NumReq*32-1:0] req_awaddr_i,
   input  logic [NumReq-1:0]    req_wvalid_i,
   input  logic [NumReq*32-1:0] req_wdata_i,
   input  logic [NumReq*4-1:0]  req_be_i,
   output logic [NumReq-1:0]    req_awready_o,
   output logic [NumReq-1:0]    req_wready_o,
   output logic [NumReq-1:0]    req_bvalid_o,
   input  logic [NumReq-1:0]    req_bready_i,
   output logic [NumReq*2-1:0]  req_bresp_o,
   output logic                 sim_awvalid_o,
   output logic [31:0]          sim_awaddr_o,
   output logic                 sim_wvalid_o,
   output logic [31:0]          sim_wdata_o,
   output logic [3:0]           sim_be_o,
   input  logic                 sim_awready_i,
   input  logic                 sim_wready_i,
   input  logic                 sim_bvalid_i,
   output logic                 sim_bready_o,
   input  logic [1:0]           sim_bresp_i,
   output logic [NumReq-1:0]    grant_o,
   output logic                 busy_o
);
   localparam int IdxW = $clog2(NumReq);
   localparam int CntW = (BTimeout > 0) ? $clog2(BTimeout + 1) : 1;
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ISSUE  = 2'd1;
   localparam logic [1:0] WAIT_B = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   logic [1:0]        state_q, state_d, bresp_q, bresp_d;
   logic [IdxW-1:0]   last_q, last_d, owner_q, owner_d, win, cand;
   logic [NumReq-1:0] grant_q, grant_d, elig, win_oh;
   logic [31:0]       addr_q, addr_d, data_q, data_d;
   logic [3:0]        be_q, be_d;
   logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic              found, accept, timeout, b_hs;

   assign elig = req_awvalid_i & req_wvalid_i;

   // Search starts one past the last completed owner so every requester gets a turn.
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= NumReq; k++) begin
         cand = IdxW'((int'(last_q) + k) % NumReq);
         if (!found && elig[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
   end

   assign win_oh  = NumReq'(1) << win;
   assign accept  = rst_ni && (state_q == IDLE) && found;
   assign cnt_inc = cnt_q + CntW'(1);
   assign timeout = (BTimeout != 0) && (cnt_inc == CntW'(BTimeout));
   assign b_hs    = (state_q == RESP) && req_bready_i[owner_q];

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      data_d  = data_q;
      be_d    = be_q;
      bresp_d = bresp_q;
      cnt_d   = (state_q == WAIT_B) ? cnt_inc : '0;
      if (accept) begin
         state_d = ISSUE;
         owner_d = win;
         grant_d = win_oh;
         addr_d  = req_awaddr_i[32*win +: 32];
         data_d  = req_wdata_i[32*win +: 32];
         be_d    = req_be_i[4*win +: 4];
      end
      if (state_q == ISSUE && sim_awready_i && sim_wready_i) state_d = WAIT_B;
      if (state_q == WAIT_B && (sim_bvalid_i || timeout)) begin
         state_d = RESP;
         bresp_d = sim_bvalid_i ? sim_bresp_i : 2'b10;
      end
      if (b_hs) begin
         state_d = IDLE;
         last_d  = owner_q;
         grant_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         last_q  <= IdxW'(NumReq - 1);
         owner_q <= '0;
         grant_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         be_q    <= '0;
         bresp_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         be_q    <= be_d;
         bresp_q <= bresp_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      req_bresp_o = '0;
      if (state_q == RESP) req_bresp_o[2*owner_q +: 2] = bresp_q;
   end

   assign req_awready_o = accept ? win_oh : '0;
   assign req_wready_o  = accept ? win_oh : '0;
   assign req_bvalid_o  = (state_q == RESP) ? grant_q : '0;
   assign sim_awvalid_o = state_q == ISSUE;
   assign sim_wvalid_o  = state_q == ISSUE;
   assign sim_bready_o  = state_q == WAIT_B;
   assign sim_awaddr_o  = addr_q;
   assign sim_wdata_o   = data_q;
   assign sim_be_o      = be_q;
   assign grant_o       = grant_q;
   assign busy_o        = state_q != IDLE;
endmodule

// File: tb/tb_sim_ctrl_arbiter.sv
// tb_sim_ctrl_arbiter: directed cycle-by-cycle bench for sim_ctrl_arbiter with two requesters.
module tb_sim_ctrl_arbiter;
   logic        clk_i = 1'b0, rst_ni = 1'b1;
   logic [1:0]  req_awvalid_i, req_wvalid_i, req_bready_i;
   logic [63:0] req_awaddr_i, req_wdata_i;
   logic [7:0]  req_be_i;
   logic [1:0]  req_awready_o, req_wready_o, req_bvalid_o;
   logic [3:0]  req_bresp_o;
   logic        sim_awvalid_o, sim_wvalid_o, sim_bready_o;
   logic [31:0] sim_awaddr_o, sim_wdata_o;
   logic [3:0]  sim_be_o;
   logic        sim_awready_i, sim_wready_i, sim_bvalid_i;
   logic [1:0]  sim_bresp_i;
   logic [1:0]  grant_o;
   logic        busy_o;
   logic [1:0]  oh;
   int          n_tests = 0, n_fail = 0;

   sim_ctrl_arbiter #(.NumReq(2), .BTimeout(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_awvalid_i(req_awvalid_i), .req_awaddr_i(req_awaddr_i),
      .req_wvalid_i(req_wvalid_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
      .req_awready_o(req_awready_o), .req_wready_o(req_wready_o),
      .req_bvalid_o(req_bvalid_o), .req_bready_i(req_bready_i), .req_bresp_o(req_bresp_o),
      .sim_awvalid_o(sim_awvalid_o), .sim_awaddr_o(sim_awaddr_o),
      .sim_wvalid_o(sim_wvalid_o), .sim_wdata_o(sim_wdata_o), .sim_be_o(sim_be_o),
      .sim_awready_i(sim_awready_i), .sim_wready_i(sim_wready_i),
      .sim_bvalid_i(sim_bvalid_i), .sim_bready_o(sim_bready_o), .sim_bresp_i(sim_bresp_i),
      .grant_o(grant_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, {busy_o, grant_o, sim_awvalid_o, sim_wvalid_o, sim_bready_o,
                            req_awready_o, req_wready_o, req_bvalid_o, req_bresp_o}, 64'h0);
      check({tag, "_dat"}, {sim_awaddr_o, sim_wdata_o}, 64'h0);
      check({tag, "_be"}, sim_be_o, 64'h0);
   endtask

   initial begin
      req_awvalid_i = '0; req_wvalid_i = '0; req_bready_i = '0;
      req_awaddr_i = '0; req_wdata_i = '0; req_be_i = '0;
      sim_awready_i = 1'b1; sim_wready_i = 1'b1; sim_bvalid_i = 1'b0; sim_bresp_i = 2'b00;
      #1 rst_ni = 1'b0;
      #1 check_all_zero("rst");
      tick(); tick();
      rst_ni = 1'b1;
      // Single char-out write from requester 0 with a zero-wait peripheral.
      req_awvalid_i = 2'b01; req_wvalid_i = 2'b01;
      req_awaddr_i[31:0] = 32'h0; req_wdata_i[31:0] = 32'h41; req_be_i[3:0] = 4'h1;
      settle();
      check("a_awready", req_awready_o, 2'b01);
      check("a_wready", req_wready_o, 2'b01);
      tick();
      req_awvalid_i = '0; req_wvalid_i = '0;
      settle();
      check("a_issue", {sim_awvalid_o, sim_wvalid_o, grant_o, busy_o}, 5'b11011);
      check("a_wdata", sim_wdata_o, 32'h41);
      check("a_be", sim_be_o, 4'h1);
      tick();
      sim_bvalid_i = 1'b1;
      settle();
      check("a_waitb", {sim_bready_o, req_bvalid_o}, 3'b100);
      tick();
      sim_bvalid_i = 1'b0; req_bready_i = 2'b01;
      settle();
      check("a_bvalid", req_bvalid_o, 2'b01);
      check("a_bresp", req_bresp_o, 4'b0000);
      tick();
      req_bready_i = '0;
      settle();
      check("a_idle", {busy_o, grant_o}, 3'b000);
      // Both requesters continuously eligible: grants alternate from requester 0.
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      req_awaddr_i = {32'h8, 32'h0}; req_wdata_i = {32'hB1, 32'hA0}; req_be_i = {4'h3, 4'hF};
      req_awvalid_i = 2'b11; req_wvalid_i = 2'b11; req_bready_i = 2'b11;
      for (int k = 0; k < 4; k++) begin
         oh = (k % 2 == 0) ? 2'b01 : 2'b10;
         settle();
         check("b_accept", {busy_o, req_awready_o, req_wready_o}, {1'b0, oh, oh});
         tick();
         settle();
         check("b_grant", grant_o, oh);
         check("b_wdata", sim_wdata_o, (k % 2 == 0) ? 32'hA0 : 32'hB1);
         tick();
         sim_bvalid_i = 1'b1;
         settle();
         check("b_waitb", {busy_o, req_awready_o, grant_o}, {1'b1, 2'b00, oh});
         tick();
         sim_bvalid_i = 1'b0;
         settle();
         check("b_resp", req_bvalid_o, oh);
         tick();
      end
      req_awvalid_i = '0; req_wvalid_i = '0; req_bready_i = '0;
      // AW without W is never granted.
      req_awvalid_i = 2'b10;
      req_awaddr_i[63:32] = 32'h8; req_wdata_i[63:32] = 32'h1234; req_be_i[7:4] = 4'hF;
      for (int k = 0; k < 5; k++) begin
         settle();
         check("c_aw_only", {busy_o, req_awready_o}, 3'b000);
         tick();
      end
      req_wvalid_i = 2'b10;
      settle();
      check("c_accept", req_awready_o, 2'b10);
      tick();
      req_awvalid_i = '0; req_wvalid_i = '0; sim_wready_i = 1'b0;
      settle();
      check("c_issue", {sim_awvalid_o, sim_wvalid_o, sim_awaddr_o}, {2'b11, 32'h8});
      tick();
      sim_wready_i = 1'b1;
      settle();
      check("c_issue_hold", {sim_awvalid_o, sim_wvalid_o, sim_bready_o}, 3'b110);
      tick();
      // Peripheral stays silent: timeout response 16 cycles after entering WAIT_B.
      for (int k = 0; k < 16; k++) begin
         settle();
         check("d_wait", {sim_bready_o, req_bvalid_o}, 3'b100);
         tick();
      end
      settle();
      check("d_timeout", req_bvalid_o, 2'b10);
      check("d_bresp", req_bresp_o, 4'b1000);
      // Response held while bready is low; requester 0 waits.
      req_awvalid_i = 2'b01; req_wvalid_i = 2'b01;
      req_awaddr_i[31:0] = 32'h2; req_wdata_i[31:0] = 32'h1; req_be_i[3:0] = 4'h1;
      for (int k = 0; k < 6; k++) begin
         settle();
         check("e_hold", {req_bvalid_o, req_bresp_o, grant_o, req_awready_o},
               {2'b10, 4'b1000, 2'b10, 2'b00});
         tick();
      end
      req_bready_i = 2'b10;
      settle();
      check("e_hs", req_bvalid_o, 2'b10);
      tick();
      req_bready_i = '0;
      settle();
      check("e_next", req_awready_o, 2'b01);
      tick();
      req_awvalid_i = '0; req_wvalid_i = '0;
      tick();
      sim_bvalid_i = 1'b1;
      tick();
      sim_bvalid_i = 1'b0; req_bready_i = 2'b01;
      settle();
      check("f_r0_resp", req_bvalid_o, 2'b01);
      tick();
      // Requester 1 is mid-flight (last owner 0) when reset hits.
      req_bready_i = '0; req_awvalid_i = 2'b10; req_wvalid_i = 2'b10;
      settle();
      check("f_r1_accept", req_awready_o, 2'b10);
      tick();
      req_awvalid_i = '0; req_wvalid_i = '0;
      tick();
      req_awvalid_i = 2'b11; req_wvalid_i = 2'b11;
      settle();
      check("f_waitb", {sim_bready_o, grant_o}, 3'b110);
      #1 rst_ni = 1'b0;
      #1 check_all_zero("f_async");
      tick();
      rst_ni = 1'b1;
      settle();
      check("f_after_rst", req_awready_o, 2'b01);
      tick();
      req_awvalid_i = '0; req_wvalid_i = '0;
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
